// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch flush and data-memory wait.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/bubble cycle counter on stall_cnt.
module hazard_ctrl (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  id_RA,
    input  logic [3:0]  id_RB,
    input  logic        id_use_RA,
    input  logic        id_use_RB,
    input  logic [3:0]  ex_WC,
    input  logic [2:0]  ex_W_RF,
    input  logic [1:0]  ex_S_MXRB,
    input  logic [3:0]  wb_WC,
    input  logic [2:0]  wb_W_RF,
    input  logic        br_taken,
    input  logic        dm_req,
    input  logic        dm_ack,
    output logic        en_pc,
    output logic        en_ifid,
    output logic        en_exmem,
    output logic        bubble,
    output logic        flush_ifid,
    output logic [1:0]  fwd_A,
    output logic [1:0]  fwd_B,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic ex_writer;
    logic ex_load;
    logic wb_writer;
    logic load_use;
    logic mem_wait;

    assign ex_writer = (ex_W_RF != 3'b000);
    assign ex_load   = ex_writer && (ex_S_MXRB == 2'b01);
    assign wb_writer = (wb_W_RF != 3'b000);
    assign load_use  = ex_load && ((id_use_RA && (ex_WC == id_RA)) ||
                                   (id_use_RB && (ex_WC == id_RB)));
    assign mem_wait  = dm_req && !dm_ack;

    // A load's data is not in EX/MEM yet, so it never forwards from there.
    always_comb begin
        fwd_A = 2'b00;
        fwd_B = 2'b00;
        if (!RESET) begin
            if (ex_writer && !ex_load && (ex_WC == id_RA))
                fwd_A = 2'b01;
            else if (wb_writer && (wb_WC == id_RA))
                fwd_A = 2'b10;
            if (ex_writer && !ex_load && (ex_WC == id_RB))
                fwd_B = 2'b01;
            else if (wb_writer && (wb_WC == id_RB))
                fwd_B = 2'b10;
        end
    end

    always_comb begin
        en_pc      = 1'b1;
        en_ifid    = 1'b1;
        en_exmem   = 1'b1;
        bubble     = 1'b0;
        flush_ifid = 1'b0;
        state_d    = state_q;
        if (RESET) begin
            en_pc      = 1'b0;
            en_ifid    = 1'b0;
            en_exmem   = 1'b0;
            bubble     = 1'b1;
            flush_ifid = 1'b1;
            state_d    = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_wait) begin
                        en_pc    = 1'b0;
                        en_ifid  = 1'b0;
                        en_exmem = 1'b0;
                        state_d  = ST_MEM_WAIT;
                    end else if (br_taken) begin
                        flush_ifid = 1'b1;
                        bubble     = 1'b1;
                        state_d    = ST_FLUSH;
                    end else if (load_use) begin
                        en_pc   = 1'b0;
                        en_ifid = 1'b0;
                        bubble  = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!dm_ack) begin
                        en_pc    = 1'b0;
                        en_ifid  = 1'b0;
                        en_exmem = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    bubble  = 1'b1;
                    state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if ((!en_pc || bubble) && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            cnt_q <= 16'h0000;
        else
            cnt_q <= cnt_d;
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: forwarding, load-use, branch flush, memory wait, reset, counter.
module tb_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  id_RA, id_RB, ex_WC, wb_WC;
    logic        id_use_RA, id_use_RB;
    logic [2:0]  ex_W_RF, wb_W_RF;
    logic [1:0]  ex_S_MXRB;
    logic        br_taken, dm_req, dm_ack;
    logic        en_pc, en_ifid, en_exmem, bubble, flush_ifid;
    logic [1:0]  fwd_A, fwd_B;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] snap;

    hazard_ctrl dut (
        .CLK(CLK), .RESET(RESET),
        .id_RA(id_RA), .id_RB(id_RB), .id_use_RA(id_use_RA), .id_use_RB(id_use_RB),
        .ex_WC(ex_WC), .ex_W_RF(ex_W_RF), .ex_S_MXRB(ex_S_MXRB),
        .wb_WC(wb_WC), .wb_W_RF(wb_W_RF),
        .br_taken(br_taken), .dm_req(dm_req), .dm_ack(dm_ack),
        .en_pc(en_pc), .en_ifid(en_ifid), .en_exmem(en_exmem),
        .bubble(bubble), .flush_ifid(flush_ifid),
        .fwd_A(fwd_A), .fwd_B(fwd_B), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // en_pc, en_ifid, en_exmem, bubble, flush_ifid packed as one vector
    task automatic check_ctl(input string tag, input logic [4:0] exp);
        check(tag, {11'd0, en_pc, en_ifid, en_exmem, bubble, flush_ifid}, {11'd0, exp});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_in();
        id_RA = 4'd0; id_RB = 4'd0; id_use_RA = 1'b0; id_use_RB = 1'b0;
        ex_WC = 4'd0; ex_W_RF = 3'd0; ex_S_MXRB = 2'd0;
        wb_WC = 4'd0; wb_W_RF = 3'd0;
        br_taken = 1'b0; dm_req = 1'b0; dm_ack = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        clear_in();
        // Forwarding-shaped inputs during reset must still give fwd = 00
        ex_WC = 4'd3; ex_W_RF = 3'd1; id_RA = 4'd3; id_use_RA = 1'b1;
        br_taken = 1'b1;
        tick(); tick();
        check_ctl("reset_ctl", 5'b00011);
        check("reset_fwdA", {14'd0, fwd_A}, 16'd0);
        check("reset_fwdB", {14'd0, fwd_B}, 16'd0);
        check("reset_cnt", stall_cnt, 16'd0);

        RESET = 1'b0;
        clear_in();
        #1;
        check_ctl("run_idle", 5'b11100);
        tick();

        // EX/MEM non-load writer beats WB on RA
        ex_WC = 4'd3; ex_W_RF = 3'd1; wb_WC = 4'd3; wb_W_RF = 3'd1;
        id_RA = 4'd3; id_use_RA = 1'b1; id_RB = 4'd7; id_use_RB = 1'b1;
        #1;
        check("fwd_ex_A", {14'd0, fwd_A}, 16'd1);
        check("fwd_ex_B", {14'd0, fwd_B}, 16'd0);
        check_ctl("fwd_ex_ctl", 5'b11100);
        tick();

        // WB-only writer on RB
        ex_W_RF = 3'd0; wb_WC = 4'd4; wb_W_RF = 3'd2; id_RB = 4'd4;
        #1;
        check("fwd_wb_A", {14'd0, fwd_A}, 16'd0);
        check("fwd_wb_B", {14'd0, fwd_B}, 16'd2);
        tick();

        // Load-use on RB: one stall cycle then WB forwarding
        clear_in();
        ex_S_MXRB = 2'b01; ex_WC = 4'd5; ex_W_RF = 3'd1;
        id_RA = 4'd3; id_use_RA = 1'b1; id_RB = 4'd5; id_use_RB = 1'b1;
        #1;
`ifdef HAZARD_PERF_CNT_EN
        snap = stall_cnt;
`endif
        check_ctl("lu_stall", 5'b00110);
        check("lu_fwdB_stall", {14'd0, fwd_B}, 16'd0);
        tick();
        ex_W_RF = 3'd0; ex_S_MXRB = 2'b00; wb_WC = 4'd5; wb_W_RF = 3'd1;
        #1;
        check_ctl("lu_after", 5'b11100);
        check("lu_fwdB_wb", {14'd0, fwd_B}, 16'd2);
`ifdef HAZARD_PERF_CNT_EN
        check("lu_cnt", stall_cnt - snap, 16'd1);
`endif
        tick();

        // Load to an unused source: no stall
        clear_in();
        ex_S_MXRB = 2'b01; ex_WC = 4'd6; ex_W_RF = 3'd1; id_RB = 4'd6; id_use_RB = 1'b0;
        #1;
        check_ctl("load_nouse", 5'b11100);
        tick();

        // Branch: flush cycle, FLUSH (br_taken ignored), back to RUN
        clear_in();
        br_taken = 1'b1;
        #1;
        check_ctl("br_c1", 5'b11111);
        tick();
        #1;
        check_ctl("br_c2_flush", 5'b11110);
        tick();
        br_taken = 1'b0;
        #1;
        check_ctl("br_c3_run", 5'b11100);
        tick();

        // Memory wait beats branch; 3 wait cycles then ack
        dm_req = 1'b1; dm_ack = 1'b0; br_taken = 1'b1;
        #1;
`ifdef HAZARD_PERF_CNT_EN
        snap = stall_cnt;
`endif
        check_ctl("mw_c1", 5'b00000);
        tick();
        dm_req = 1'b0;
        #1;
        check_ctl("mw_c2", 5'b00000);
        tick();
        #1;
        check_ctl("mw_c3", 5'b00000);
        tick();
        dm_ack = 1'b1;
        #1;
        check_ctl("mw_ack", 5'b11100);
`ifdef HAZARD_PERF_CNT_EN
        check("mw_cnt", stall_cnt - snap, 16'd3);
`else
        check("mw_cnt_off", stall_cnt, 16'd0);
`endif
        tick();
        clear_in();
        #1;
        check_ctl("mw_done_run", 5'b11100);
        tick();

        // Request acknowledged in the same cycle: no wait
        dm_req = 1'b1; dm_ack = 1'b1;
        #1;
        check_ctl("req_ack_same", 5'b11100);
        tick();
        clear_in();
        #1;
        check_ctl("req_ack_next", 5'b11100);
        tick();

        // Reset mid-MEM_WAIT
        dm_req = 1'b1;
        tick();
        dm_req = 1'b0;
        #1;
        check_ctl("rst_mw_pre", 5'b00000);
        RESET = 1'b1;
        #1;
        check_ctl("rst_mw_ctl", 5'b00011);
        check("rst_mw_cnt", stall_cnt, 16'd0);
        RESET = 1'b0;
        #1;
        check_ctl("rst_mw_after", 5'b11100);
        tick();

        // Reset mid-FLUSH
        br_taken = 1'b1;
        tick();
        br_taken = 1'b0;
        RESET = 1'b1;
        #1;
        check_ctl("rst_fl_ctl", 5'b00011);
        RESET = 1'b0;
        #1;
        check_ctl("rst_fl_after", 5'b11100);
        tick();

        // Long memory wait: counter saturates (or stays zero without the counter)
        dm_req = 1'b1; dm_ack = 1'b0;
        for (int i = 0; i < 70000; i++) tick();
        dm_req = 1'b0;
        #1;
`ifdef HAZARD_PERF_CNT_EN
        check("cnt_sat", stall_cnt, 16'hFFFF);
`else
        check("cnt_off", stall_cnt, 16'h0000);
`endif
        check_ctl("long_wait", 5'b00000);
        dm_ack = 1'b1;
        tick();
        clear_in();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
